// File: rtl/fxp_to_half_if.sv
// Operand/result handshake bundle for the fixed-point to half-precision converter.
// The master side supplies operands and consumes results; the converter is the slave.
interface fxp_to_half_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [15:0] in_int;
  logic [31:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_half;
  logic        out_underflow;

  modport master (
    output in_valid, in_sign, in_int, in_frac, out_ready,
    input  in_ready, out_valid, out_half, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_int, in_frac, out_ready,
    output in_ready, out_valid, out_half, out_underflow
  );
endinterface

// File: rtl/fxp_to_half.sv
// Sign-magnitude 16.32 fixed point to IEEE-754 half converter: one-bit-per-cycle
// normalization, truncating rounding, flush-to-signed-zero below the normal range.
module fxp_to_half (
  input  logic          clk,
  input  logic          rst_n,
  fxp_to_half_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [47:0] sh_q, sh_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [15:0] half_q, half_d;
  logic        uf_q, uf_d;
  logic [4:0]  exp_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      half_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      half_q  <= half_d;
      uf_q    <= uf_d;
    end
  end

  // The leading one at sh[47] is worth 2^15, so the biased exponent is 30 minus
  // the number of shifts already taken; cnt == 30 would mean exponent 0.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    half_d  = half_q;
    uf_d    = uf_q;
    exp_val = 5'd30 - cnt_q[4:0];

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sgn_d   = bus.in_sign;
          sh_d    = {bus.in_int, bus.in_frac};
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (sh_q == '0) begin
          half_d  = {sgn_q, 15'h0000};
          uf_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == 6'd30) begin
          half_d  = {sgn_q, 15'h0000};
          uf_d    = 1'b1;
          state_d = DONE;
        end else if (sh_q[47]) begin
          half_d  = {sgn_q, exp_val, sh_q[46:37]};
          uf_d    = 1'b0;
          state_d = DONE;
        end else begin
          sh_d  = {sh_q[46:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_half      = half_q;
  assign bus.out_underflow = uf_q;

endmodule

// File: tb/tb_fxp_to_half.sv
// Scoreboard bench for fxp_to_half: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_fxp_to_half;

  typedef struct {
    logic [15:0] half;
    logic        uf;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fxp_to_half_if bus();

  fxp_to_half dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t cur;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Latency is the edge count from the accept edge to the first edge showing out_valid.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          check_output("unexpected_valid", 32'd1, 32'd0);
        end else begin
          cur  = sb.pop_front();
          seen = 1'b1;
          check_output("half", {16'h0, bus.out_half}, {16'h0, cur.half});
          check_output("underflow", {31'h0, bus.out_underflow}, {31'h0, cur.uf});
          check_output("latency", cyc - cur.acc, cur.lat);
        end
      end else begin
        check_output("hold_half", {16'h0, bus.out_half}, {16'h0, cur.half});
        check_output("hold_underflow", {31'h0, bus.out_underflow}, {31'h0, cur.uf});
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic sgn, input logic [15:0] ip, input logic [31:0] fp,
                                input logic [15:0] half, input logic uf, input int lat);
    int   w;
    exp_t e;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check_output("accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_sign  = sgn;
    bus.in_int   = ip;
    bus.in_frac  = fp;
    e.half = half;
    e.uf   = uf;
    e.lat  = lat;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'($urandom);
    bus.in_int   = 16'($urandom);
    bus.in_frac  = $urandom;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || bus.out_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check_output("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_int    = '0;
    bus.in_frac   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check_output("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check_output("rst_out_half", {16'h0, bus.out_half}, 32'h0);
    check_output("rst_underflow", {31'h0, bus.out_underflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Truncation keeps 0x2C4C: the discarded tail is not rounded up.
    apply_stimulus(1'b0, 16'h0000, 32'h1133_2A2A, 16'h2C4C, 1'b0, 20); wait_drain();
    apply_stimulus(1'b0, 16'h0001, 32'h7333_3333, 16'h3DCC, 1'b0, 16); wait_drain();
    apply_stimulus(1'b1, 16'hFFFF, 32'hFFFF_FFFF, 16'hFBFF, 1'b0, 1);  wait_drain();
    apply_stimulus(1'b0, 16'hFFFF, 32'hFFFF_FFFF, 16'h7BFF, 1'b0, 1);  wait_drain();
    apply_stimulus(1'b0, 16'h0000, 32'h0004_0000, 16'h0400, 1'b0, 30); wait_drain();
    apply_stimulus(1'b1, 16'h0000, 32'h0002_0000, 16'h8000, 1'b1, 31); wait_drain();
    apply_stimulus(1'b0, 16'h0000, 32'h0000_0001, 16'h0000, 1'b1, 31); wait_drain();
    apply_stimulus(1'b0, 16'h0000, 32'h0000_0000, 16'h0000, 1'b0, 1);  wait_drain();
    apply_stimulus(1'b1, 16'h0000, 32'h0000_0000, 16'h8000, 1'b0, 1);  wait_drain();

    // Backpressure: 2.5 held for 10 cycles while stray operands are offered.
    bus.out_ready = 1'b0;
    apply_stimulus(1'b0, 16'h0002, 32'h8000_0000, 16'h4100, 1'b0, 15);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_output("bp_valid_seen", {31'h0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("bp_in_ready", {31'h0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b1;
      bus.in_int   = 16'($urandom);
      bus.in_frac  = $urandom;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("release_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check_output("release_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check_output("idle_keeps_half", {16'h0, bus.out_half}, 32'h4100);
    apply_stimulus(1'b0, 16'h0001, 32'h7333_3333, 16'h3DCC, 1'b0, 16); wait_drain();

    // Reset in the middle of normalizing 1.45 discards it.
    apply_stimulus(1'b0, 16'h0001, 32'h7333_3333, 16'h3DCC, 1'b0, 16);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_output("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    check_output("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check_output("mid_rst_out_half", {16'h0, bus.out_half}, 32'h0);
    check_output("mid_rst_underflow", {31'h0, bus.out_underflow}, 32'd0);
    @(negedge clk);
    check_output("mid_rst_hold_valid", {31'h0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b0, 16'h0001, 32'h7333_3333, 16'h3DCC, 1'b0, 16); wait_drain();
    apply_stimulus(1'b0, 16'h0000, 32'h1133_2A2A, 16'h2C4C, 1'b0, 20); wait_drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
